// File: rtl/pwm_bank_pkg.sv
// Shared register map, control bit positions and counter direction
// type for the PWM bank and its timebase.
package pwm_bank_pkg;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_PERIOD   = 1;
  localparam int ADDR_PRESCALE = 2;
  localparam int ADDR_DUTY0    = 3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CENTER = 1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus edge / center-aligned period counter.
// Ports: clk, rst_n, ena_i (freeze), en_i, center_i, top_i, presc_i -> cnt_o, boundary_o.
module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int CW = 8,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena_i,
  input  logic          en_i,
  input  logic          center_i,
  input  logic [CW-1:0] top_i,
  input  logic [PW-1:0] presc_i,
  output logic [CW-1:0] cnt_o,
  output logic          boundary_o
);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  dir_e          dir_q, dir_d;
  logic          tick;
  logic          bnd;

  always_comb begin
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    bnd    = 1'b0;
    tick   = en_i & (pcnt_q == presc_i);
    if (!en_i) begin
      pcnt_d = '0;
      cnt_d  = '0;
      dir_d  = DIR_UP;
    end else begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      if (!center_i) dir_d = DIR_UP;
      if (tick) begin
        if (top_i == '0) begin
          cnt_d = '0;
          dir_d = DIR_UP;
          bnd   = 1'b1;
        end else if (!center_i) begin
          bnd   = (cnt_q == top_i);
          cnt_d = bnd ? '0 : cnt_q + 1'b1;
        end else if (dir_q == DIR_UP) begin
          // turn around at the apex without dwelling on TOP
          if (cnt_q == top_i) begin
            dir_d = DIR_DOWN;
            cnt_d = cnt_q - 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == '0) begin
            bnd   = 1'b1;
            dir_d = DIR_UP;
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
    end else if (ena_i) begin
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign boundary_o = bnd;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM: register file, shadow->active load, comparators.
// Ports: clk, rst_n, ena, wr_en/addr/wr_data, rd_data, pwm_out, period_start.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CW   = 8,
  parameter int PW   = 8,
  localparam int DW  = (CW > PW) ? CW : PW,
  localparam int AW  = $clog2(NCH + 3)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           wr_en,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  wr_data,
  output logic [DW-1:0]  rd_data,
  output logic [NCH-1:0] pwm_out,
  output logic           period_start
);

  logic [1:0]    ctrl_q;
  logic [CW-1:0] top_sh_q;
  logic [PW-1:0] presc_q;
  logic [CW-1:0] duty_sh_q [NCH];

  logic [CW-1:0] top_act_q;
  logic [CW-1:0] duty_act_q [NCH];

  logic [NCH-1:0] pwm_q;
  logic [NCH-1:0] pwm_d;
  logic           ps_q;
  logic [CW-1:0]  cnt;
  logic           boundary;
  logic           en;

  assign en = ctrl_q[CTRL_EN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      top_sh_q <= '0;
      presc_q  <= '0;
      for (int i = 0; i < NCH; i++) duty_sh_q[i] <= '0;
    end else if (ena && wr_en) begin
      if (addr == AW'(ADDR_CTRL))     ctrl_q   <= wr_data[1:0];
      if (addr == AW'(ADDR_PERIOD))   top_sh_q <= wr_data[CW-1:0];
      if (addr == AW'(ADDR_PRESCALE)) presc_q  <= wr_data[PW-1:0];
      for (int i = 0; i < NCH; i++)
        if (addr == AW'(ADDR_DUTY0 + i))
          duty_sh_q[i] <= wr_data[CW-1:0];
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr == AW'(ADDR_CTRL))     rd_data = DW'(ctrl_q);
    if (addr == AW'(ADDR_PERIOD))   rd_data = DW'(top_sh_q);
    if (addr == AW'(ADDR_PRESCALE)) rd_data = DW'(presc_q);
    for (int i = 0; i < NCH; i++)
      if (addr == AW'(ADDR_DUTY0 + i))
        rd_data = DW'(duty_sh_q[i]);
  end

  pwm_timebase #(
    .CW(CW),
    .PW(PW)
  ) u_tb (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena_i     (ena),
    .en_i      (en),
    .center_i  (ctrl_q[CTRL_CENTER]),
    .top_i     (top_act_q),
    .presc_i   (presc_q),
    .cnt_o     (cnt),
    .boundary_o(boundary)
  );

  // while stopped the active set mirrors the shadows, so a
  // fresh start always runs with the latest programmed values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_act_q <= '0;
      for (int i = 0; i < NCH; i++) duty_act_q[i] <= '0;
    end else if (ena && (!en || boundary)) begin
      top_act_q <= top_sh_q;
      for (int i = 0; i < NCH; i++) duty_act_q[i] <= duty_sh_q[i];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cmp
    assign pwm_d[g] = en & (cnt < duty_act_q[g]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
      ps_q  <= 1'b0;
    end else if (ena) begin
      pwm_q <= pwm_d;
      ps_q  <= boundary & en;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed self-checking bench for pwm_bank.
// Drives and samples on the falling edge.
module tb_pwm_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PW  = 8;
  localparam int DW  = 8;
  localparam int AW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b1;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [DW-1:0]  wr_data = '0;
  logic [DW-1:0]  rd_data;
  logic [NCH-1:0] pwm_out;
  logic           period_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_bank #(
    .NCH(NCH),
    .CW (CW),
    .PW (PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .wr_en       (wr_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    addr    = AW'(a);
    wr_data = DW'(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic rd(input string tag, input int a, input int exp);
    addr = AW'(a);
    #1;
    check(tag, int'(rd_data), exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    ena   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int h0, h1, h2, hp, p, d, m, c;

    do_reset();
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ps", int'(period_start), 0);
    rd("rst_period", 1, 0);
    rd("rst_duty0", 3, 0);

    // edge mode, TOP=9, duty 3 and 5
    wr(1, 9); wr(2, 0); wr(3, 3); wr(4, 5); wr(0, 1);
    check("t1_start", int'(pwm_out), 0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("t1_pwm0", int'(pwm_out[0]), int'(k % 10 >= 1 && k % 10 <= 3));
      check("t1_pwm1", int'(pwm_out[1]), int'(k % 10 >= 1 && k % 10 <= 5));
      check("t1_ps", int'(period_start), int'(k % 10 == 0));
    end

    // duty 0 / duty > TOP / 50%
    wr(3, 0); wr(5, 10);
    rd("t2_duty2_rd", 5, 10);
    repeat (20) @(negedge clk);
    h0 = 0; h1 = 0; h2 = 0; hp = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
      hp += int'(period_start);
    end
    check("t2_duty0_zero", h0, 0);
    check("t2_duty1_half", h1, 5);
    check("t2_duty2_full", h2, 10);
    check("t2_ps_count", hp, 1);

    // shadowed duty update mid-period and on the boundary edge
    do_reset();
    wr(1, 9); wr(3, 3); wr(0, 1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      p = (k - 1) / 10;
      d = (p == 1 || p == 2) ? 7 : 3;
      check("t3_pwm0", int'(pwm_out[0]), int'((k - 1) % 10 < d));
      check("t3_ps", int'(period_start), int'(k % 10 == 0));
      if (k == 4) begin
        wr_en = 1'b1; addr = 3'd3; wr_data = 8'd7;
      end else if (k == 19) begin
        wr_en = 1'b1; addr = 3'd3; wr_data = 8'd3;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;

    // center-aligned, TOP=4, duty 2
    do_reset();
    wr(1, 4); wr(3, 2); wr(0, 3);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      m = (k - 1) % 8;
      c = (m <= 4) ? m : 8 - m;
      check("t4_pwm0", int'(pwm_out[0]), int'(c < 2));
      check("t4_ps", int'(period_start), int'(k > 1 && k % 8 == 1));
    end

    // prescale 2, edge, TOP=3, duty 2
    do_reset();
    wr(1, 3); wr(2, 2); wr(3, 2); wr(0, 1);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      c = ((k - 1) / 3) % 4;
      check("t5_pwm0", int'(pwm_out[0]), int'(c < 2));
      check("t5_ps", int'(period_start), int'(k % 12 == 0));
    end

    // EN drop, freeze, async reset, unmapped address
    do_reset();
    wr(1, 9); wr(3, 8); wr(0, 1);
    repeat (2) @(negedge clk);
    check("t6_run_high", int'(pwm_out[0]), 1);
    wr(0, 0);
    check("t6_en_lag", int'(pwm_out[0]), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_en_off_pwm", int'(pwm_out), 0);
      check("t6_en_off_ps", int'(period_start), 0);
    end
    wr(0, 1);
    repeat (2) @(negedge clk);
    check("t6_rerun_high", int'(pwm_out[0]), 1);
    ena = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_freeze", int'(pwm_out[0]), 1);
    ena = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("t6_async_pwm", int'(pwm_out), 0);
    rd("t6_async_period", 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr(1, 9);
    wr(7, 8'hAA);
    rd("t6_unmapped_rd", 7, 0);
    rd("t6_period_intact", 1, 9);
    rd("t6_ctrl_intact", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
